zxuno_uart_rx: RTL and testbench

- Receive front end for the ZX-Uno register-mapped UART.
- Sits between the `uart_rx` pin and the UART register logic that services CPU reads of the data and status registers.
- Oversamples the line at 4x baud and deframes 8N1 characters.
- Buffers received bytes in a small FIFO and drives hardware flow control (`uart_rts`) from FIFO occupancy.

---
 rtl/zxuno_uart_rx_pkg.sv | 20 ++
 rtl/zxuno_uart_rx_if.sv | 27 ++
 rtl/zxuno_uart_rx_fifo.sv | 54 +++++
 rtl/zxuno_uart_rx.sv | 181 ++++++++++++++++++
 tb/tb_zxuno_uart_rx.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/zxuno_uart_rx_pkg.sv
// Shared definitions for the ZX-Uno UART receive path and its register logic.
package zxuno_uart_pkg;

  // Receiver deframing FSM encoding.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_t;

  localparam int OVERSAMPLE = 4;
  localparam int DATA_BITS  = 8;

  // ZX-Uno register numbers serviced by the UART register logic.
  localparam logic [7:0] UART_DATA_REG = 8'hC6;
  localparam logic [7:0] UART_STAT_REG = 8'hC7;

endpackage

// File: rtl/zxuno_uart_rx_if.sv
// Register-side bus of the UART receiver: CPU pop/clear strobes in,
// FIFO head, occupancy and sticky error flags out.
interface zxuno_uart_rx_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rd_pop;
  logic          clr_err;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [CW-1:0] rx_count;
  logic          frame_err;
  logic          overrun;

  // UART register logic side.
  modport master (
    output rd_pop, clr_err,
    input  rx_data, rx_valid, rx_count, frame_err, overrun
  );

  // Receiver side.
  modport slave (
    input  rd_pop, clr_err,
    output rx_data, rx_valid, rx_count, frame_err, overrun
  );
endinterface

// File: rtl/zxuno_uart_rx_fifo.sv
// Synchronous receive FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate counter. A push into a full
// FIFO is still accepted when a pop happens in the same clk.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; a pop on an empty FIFO leaves the read pointer alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is cleared on reset so the head reads 0x00 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/zxuno_uart_rx.sv
// ZX-Uno UART receive front end: 4x oversampled 8N1 deframer, receive FIFO,
// sticky error flags and RTS flow control with hysteresis.
//
// state        | meaning
// ST_IDLE      | line idle, waiting for a low sample
// ST_START     | confirming start bit at its middle
// ST_DATA      | sampling 8 data bits, LSB first
// ST_STOP      | sampling stop bit, push or flag frame error
// ST_WAIT_IDLE | after a frame error, wait for the line to go high
module zxuno_uart_rx
  import zxuno_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int RTS_HIGH   = 12,
  parameter int RTS_LOW    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bit_clk4x,
  input  logic                  uart_rx,
  output logic                  uart_rts,
  zxuno_uart_rx_if.slave        bus
);
  localparam int         CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0] PH_LAST = 2'(OVERSAMPLE - 1);
  localparam logic [1:0] PH_MID  = 2'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0] BN_LAST = 3'(DATA_BITS - 1);

  logic      rx_meta, rxs;
  logic      bclk_meta, bclk_sync, bclk_prev;
  logic      tick;

  rx_state_t state_q, state_d;
  logic [1:0] ph_q, ph_d;
  logic [2:0] bn_q, bn_d;
  logic [7:0] shift_q, shift_d;
  logic       byte_push;
  logic       frame_set;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          overrun_set;

  // Synchronise the serial line (idles high) and the oversample clock level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      bclk_meta <= 1'b0;
      bclk_sync <= 1'b0;
      bclk_prev <= 1'b0;
    end else begin
      rx_meta   <= uart_rx;
      rxs       <= rx_meta;
      bclk_meta <= bit_clk4x;
      bclk_sync <= bclk_meta;
      bclk_prev <= bclk_sync;
    end
  end

  assign tick = bclk_sync && !bclk_prev;

  // Deframer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      bn_q    <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bn_q    <= bn_d;
      shift_q <= shift_d;
    end
  end

  // Deframer next state; everything advances only on oversample ticks.
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    bn_d      = bn_q;
    shift_d   = shift_q;
    byte_push = 1'b0;
    frame_set = 1'b0;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rxs) begin
            state_d = ST_START;
            ph_d    = '0;
          end
        end
        ST_START: begin
          ph_d = ph_q + 2'd1;
          if (ph_q == PH_MID) begin
            if (rxs) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              ph_d    = '0;
              bn_d    = '0;
            end
          end
        end
        ST_DATA: begin
          ph_d = ph_q + 2'd1;
          if (ph_q == PH_LAST) begin
            shift_d[bn_q] = rxs;
            bn_d          = bn_q + 3'd1;
            if (bn_q == BN_LAST) begin
              state_d = ST_STOP;
              ph_d    = '0;
            end
          end
        end
        ST_STOP: begin
          ph_d = ph_q + 2'd1;
          if (ph_q == PH_LAST) begin
            if (rxs) begin
              byte_push = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              frame_set = 1'b1;
              state_d   = ST_WAIT_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (rxs) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (byte_push),
    .push_data (shift_q),
    .pop       (bus.rd_pop),
    .head      (bus.rx_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign overrun_set  = byte_push && fifo_full && !bus.rd_pop;
  assign bus.rx_valid = !fifo_empty;
  assign bus.rx_count = fifo_count;

  // Sticky error flags; a set in the same clk as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      if (frame_set)        bus.frame_err <= 1'b1;
      else if (bus.clr_err) bus.frame_err <= 1'b0;
      if (overrun_set)      bus.overrun   <= 1'b1;
      else if (bus.clr_err) bus.overrun   <= 1'b0;
    end
  end

  // RTS with hysteresis between the low and high occupancy marks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_rts <= 1'b0;
    end else if (fifo_count >= CW'(RTS_HIGH)) begin
      uart_rts <= 1'b1;
    end else if (fifo_count < CW'(RTS_LOW)) begin
      uart_rts <= 1'b0;
    end
  end

endmodule

// File: tb/tb_zxuno_uart_rx.sv
// Bench for zxuno_uart_rx: directed 8N1 frames, expected bytes queued at
// send time and checked by a monitor on every accepted CPU pop.
module tb_zxuno_uart_rx;
  localparam int BIT_CLKS = 208;   // 4 x 52 clk oversample periods

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic bit_clk4x = 1'b0;
  logic uart_rx   = 1'b1;
  logic uart_rts;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q [$];
  logic [7:0] exp_b;

  zxuno_uart_rx_if #(.FIFO_DEPTH(16)) bus ();

  zxuno_uart_rx #(
    .FIFO_DEPTH (16),
    .RTS_HIGH   (12),
    .RTS_LOW    (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_clk4x (bit_clk4x),
    .uart_rx   (uart_rx),
    .uart_rts  (uart_rts),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always #260 bit_clk4x = ~bit_clk4x;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every pop that the DUT accepts must present the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && bus.rd_pop && bus.rx_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL pop_unexpected: got 0x%0h expected no data", bus.rx_data);
      end else begin
        exp_b = exp_q.pop_front();
        chk("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_b});
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop);
    uart_rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    uart_rx = stop;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!bus.rx_valid && n < 3 * BIT_CLKS) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rx_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: rx_valid still 0 after %0d clks, expected 1", name, n);
    end
  endtask

  task automatic pop_one();
    @(posedge clk); #1;
    bus.rd_pop = 1'b1;
    @(posedge clk); #1;
    bus.rd_pop = 1'b0;
  endtask

  task automatic clr_pulse();
    @(posedge clk); #1;
    bus.clr_err = 1'b1;
    @(posedge clk); #1;
    bus.clr_err = 1'b0;
  endtask

  // Align to the clk in which the deframer pushes a byte (used only for timing).
  task automatic sync_to_push(input string name, output logic hit);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!dut.byte_push && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    hit = dut.byte_push;
    if (!hit) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no push seen within %0d clks", name, n);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic hit;
    bus.rd_pop  = 1'b0;
    bus.clr_err = 1'b0;
    repeat (5) @(negedge clk);

    chk("rst_count", 32'(bus.rx_count), 0);
    chk("rst_valid", 32'(bus.rx_valid), 0);
    chk("rst_data",  32'(bus.rx_data), 0);
    chk("rst_ferr",  32'(bus.frame_err), 0);
    chk("rst_ovr",   32'(bus.overrun), 0);
    chk("rst_rts",   32'(uart_rts), 0);
    rst_n = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);

    // basic receive and pop
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_valid("basic_valid");
    chk("basic_count", 32'(bus.rx_count), 1);
    pop_one();
    chk("basic_pop_valid", 32'(bus.rx_valid), 0);
    chk("basic_pop_count", 32'(bus.rx_count), 0);

    // pop on empty must not underflow
    pop_one();
    chk("underflow_count", 32'(bus.rx_count), 0);
    chk("underflow_valid", 32'(bus.rx_valid), 0);

    // one oversample period of low is a false start
    uart_rx = 1'b0;
    repeat (52) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("glitch_count", 32'(bus.rx_count), 0);
    chk("glitch_ferr",  32'(bus.frame_err), 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_valid("glitch_next");
    pop_one();

    // framing error then break: one error event only
    send_frame(8'h55, 1'b0);
    chk("ferr_set",   32'(bus.frame_err), 1);
    chk("ferr_count", 32'(bus.rx_count), 0);
    clr_pulse();
    repeat (3 * BIT_CLKS) @(negedge clk);
    chk("break_single_event", 32'(bus.frame_err), 0);
    chk("break_count", 32'(bus.rx_count), 0);
    uart_rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    wait_valid("after_break");
    chk("after_break_ferr", 32'(bus.frame_err), 0);
    pop_one();

    // fill to full, watching RTS
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
      chk("fill_count", 32'(bus.rx_count), 32'(i + 1));
      chk("fill_rts",   32'(uart_rts), (i + 1 >= 12) ? 32'd1 : 32'd0);
    end
    chk("fill_ovr", 32'(bus.overrun), 0);

    // 17th byte overruns; a clear in the same clk must lose to the set
    fork
      send_frame(8'h10, 1'b1);
      begin
        sync_to_push("ovr_push", hit);
        bus.clr_err = 1'b1;
        @(posedge clk); #1;
        bus.clr_err = 1'b0;
      end
    join
    chk("ovr_set",   32'(bus.overrun), 1);
    chk("ovr_count", 32'(bus.rx_count), 16);
    chk("ovr_ferr",  32'(bus.frame_err), 0);
    clr_pulse();
    chk("ovr_clear", 32'(bus.overrun), 0);

    // full FIFO: pop in the push clk accepts the new byte at the tail
    exp_q.push_back(8'hEE);
    fork
      send_frame(8'hEE, 1'b1);
      begin
        sync_to_push("coll_push", hit);
        bus.rd_pop = 1'b1;
        @(posedge clk); #1;
        bus.rd_pop = 1'b0;
      end
    join
    chk("coll_ovr",   32'(bus.overrun), 0);
    chk("coll_count", 32'(bus.rx_count), 16);

    // drain; RTS drops once occupancy falls below 8
    for (int i = 0; i < 16; i++) begin
      pop_one();
      repeat (2) @(negedge clk);
      chk("drain_count", 32'(bus.rx_count), 32'(15 - i));
      chk("drain_rts",   32'(uart_rts), (15 - i >= 8) ? 32'd1 : 32'd0);
    end
    chk("drain_valid", 32'(bus.rx_valid), 0);

    // reset in the middle of a frame with two bytes queued
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1);
    chk("pre_rst_count", 32'(bus.rx_count), 2);
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (5 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_count", 32'(bus.rx_count), 0);
        chk("midrst_valid", 32'(bus.rx_valid), 0);
        chk("midrst_rts",   32'(uart_rts), 0);
        chk("midrst_data",  32'(bus.rx_data), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (BIT_CLKS) @(negedge clk);
    chk("post_rst_count", 32'(bus.rx_count), 0);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    wait_valid("post_rst_valid");
    chk("post_rst_count1", 32'(bus.rx_count), 1);
    pop_one();
    repeat (4) @(negedge clk);

    chk("all_expected_popped", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
